// File: rtl/decode_ctrl_pipe.sv
// Registered RV32 decode stage with valid/ready handshakes, a 2-entry skid buffer, flush and illegal counting.
// Build option: define DECODE_MUL_EN to decode R-type funct7=0000001/f3=0 as MUL.
module decode_ctrl_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [3:0]       alu_ctrl,
  output logic             regwrite,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [XLEN-1:0]  imm,
  output logic             alu_src_imm,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010, ALU_SLL = 4'b0011,
    ALU_SUB  = 4'b0100, ALU_SRL = 4'b0101, ALU_MUL = 4'b0110, ALU_XOR = 4'b0111,
    ALU_SLT  = 4'b1000, ALU_SRA = 4'b1001, ALU_SLTU = 4'b1010
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    alu_op_e         alu_ctrl;
    logic            regwrite;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            alu_src_imm;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            illegal;
  } bundle_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  alu_op_e         f3_op;
  logic            legal;
  bundle_t         dec;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  // funct3 to ALU op shared by R-type and I-ALU; shift encodings are refined by funct7 below.
  always_comb begin
    case (funct3)
      3'd0:    f3_op = ALU_ADD;
      3'd1:    f3_op = ALU_SLL;
      3'd2:    f3_op = ALU_SLT;
      3'd3:    f3_op = ALU_SLTU;
      3'd4:    f3_op = ALU_XOR;
      3'd5:    f3_op = ALU_SRL;
      3'd6:    f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  end

  // NOTE: every field gets a default before the case so no path leaves a value unassigned (no latches).
  always_comb begin
    dec          = '0;
    dec.pc       = in_pc;
    dec.rd       = instr[11:7];
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.alu_ctrl = ALU_ADD;
    legal        = 1'b0;
    case (opcode)
      OP_R: begin
        dec.regwrite = 1'b1;
        case (funct7)
          7'b0000000: begin legal = 1'b1; dec.alu_ctrl = f3_op; end
          7'b0100000: begin
            if (funct3 == 3'd0) begin legal = 1'b1; dec.alu_ctrl = ALU_SUB; end
            if (funct3 == 3'd5) begin legal = 1'b1; dec.alu_ctrl = ALU_SRA; end
          end
`ifdef DECODE_MUL_EN
          7'b0000001: if (funct3 == 3'd0) begin legal = 1'b1; dec.alu_ctrl = ALU_MUL; end
`endif
          default: ;
        endcase
      end
      OP_I: begin
        dec.regwrite    = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm         = imm_i;
        dec.alu_ctrl    = f3_op;
        case (funct3)
          3'd1:    legal = (funct7 == 7'b0000000);
          3'd5: begin
            legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            if (funct7 == 7'b0100000) dec.alu_ctrl = ALU_SRA;
          end
          default: legal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        legal           = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
        dec.regwrite    = 1'b1;
        dec.mem_read    = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm         = imm_i;
      end
      OP_STORE: begin
        legal           = (funct3 <= 3'd2);
        dec.mem_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm         = imm_s;
      end
      OP_BRANCH: begin
        legal        = (funct3 != 3'd2) && (funct3 != 3'd3);
        dec.branch   = 1'b1;
        dec.alu_ctrl = ALU_SUB;
        dec.imm      = imm_b;
      end
      default: ;
    endcase
    if (!legal) begin
      dec.illegal     = 1'b1;
      dec.regwrite    = 1'b0;
      dec.mem_read    = 1'b0;
      dec.mem_write   = 1'b0;
      dec.branch      = 1'b0;
      dec.alu_src_imm = 1'b0;
      dec.alu_ctrl    = ALU_ADD;
      dec.imm         = '0;
    end
  end

  bundle_t          main_q, main_d, skid_q, skid_d;
  logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_fire, out_fire;

  assign in_ready = !skid_v_q;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_v_q && out_ready;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (main_v_q && !out_ready) begin
      // Main is stalled; an accepted input can only land in the (empty) skid slot.
      if (in_fire) begin
        skid_d   = dec;
        skid_v_d = 1'b1;
      end
    end else if (skid_v_q) begin
      main_d   = skid_q;
      main_v_d = 1'b1;
      skid_v_d = 1'b0;
    end else begin
      main_d   = in_fire ? dec : main_q;
      main_v_d = in_fire;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!flush && out_fire && main_q.illegal && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state updates use non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid     = main_v_q;
  assign out_pc        = main_q.pc;
  assign alu_ctrl      = main_q.alu_ctrl;
  assign regwrite      = main_q.regwrite;
  assign rd            = main_q.rd;
  assign rs1           = main_q.rs1;
  assign rs2           = main_q.rs2;
  assign imm           = main_q.imm;
  assign alu_src_imm   = main_q.alu_src_imm;
  assign mem_read      = main_q.mem_read;
  assign mem_write     = main_q.mem_write;
  assign branch        = main_q.branch;
  assign illegal       = main_q.illegal;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed-vector bench for decode_ctrl_pipe (CNT_W=2 so saturation is reachable); expectations are hand-computed.
module tb_decode_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, in_pc, out_pc, imm;
  logic [3:0]  alu_ctrl;
  logic        regwrite, alu_src_imm, mem_read, mem_write, branch, illegal;
  logic [4:0]  rd, rs1, rs2;
  logic [1:0]  illegal_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;

  decode_ctrl_pipe #(.XLEN(32), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alu_ctrl(alu_ctrl), .regwrite(regwrite), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .alu_src_imm(alu_src_imm), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .illegal(illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bundle(input string t, input logic [31:0] pc, input logic [3:0] alu,
                               input logic rw, input logic src, input logic mr, input logic mw,
                               input logic br, input logic ill, input logic [31:0] imm_e);
    check({t, ".out_valid"}, out_valid, 1);
    check({t, ".out_pc"}, out_pc, pc);
    check({t, ".alu_ctrl"}, alu_ctrl, alu);
    check({t, ".regwrite"}, regwrite, rw);
    check({t, ".alu_src_imm"}, alu_src_imm, src);
    check({t, ".mem_read"}, mem_read, mr);
    check({t, ".mem_write"}, mem_write, mw);
    check({t, ".branch"}, branch, br);
    check({t, ".illegal"}, illegal, ill);
    check({t, ".imm"}, imm, imm_e);
  endtask

  task automatic expect_zero(input string t);
    check({t, ".out_valid"}, out_valid, 0);
    check({t, ".out_pc"}, out_pc, 0);
    check({t, ".alu_ctrl"}, alu_ctrl, 0);
    check({t, ".regwrite"}, regwrite, 0);
    check({t, ".regs"}, {rd, rs1, rs2}, 0);
    check({t, ".imm"}, imm, 0);
    check({t, ".ctrl"}, {alu_src_imm, mem_read, mem_write, branch, illegal}, 0);
    check({t, ".illegal_count"}, illegal_count, 0);
    check({t, ".in_ready"}, in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; in_pc = '0; out_ready = 1'b0;
    #2;
    expect_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic R-type, then back-to-back streaming at one bundle per cycle.
    in_valid = 1'b1; out_ready = 1'b1; instr = 32'h002081B3; in_pc = 32'h100;
    tick;
    expect_bundle("add", 32'h100, 4'b0010, 1, 0, 0, 0, 0, 0, 32'h0);
    check("add.regs", {rd, rs1, rs2}, {5'd3, 5'd1, 5'd2});
    instr = 32'h402081B3; in_pc = 32'h104;
    tick;
    expect_bundle("sub", 32'h104, 4'b0100, 1, 0, 0, 0, 0, 0, 32'h0);
    instr = 32'hFFF00293; in_pc = 32'h108;
    tick;
    expect_bundle("addi", 32'h108, 4'b0010, 1, 1, 0, 0, 0, 0, 32'hFFFFFFFF);
    check("addi.rd", rd, 5);
    instr = 32'h4032D293; in_pc = 32'h10C;
    tick;
    expect_bundle("srai", 32'h10C, 4'b1001, 1, 1, 0, 0, 0, 0, 32'h403);
    instr = 32'h00412303; in_pc = 32'h110;
    tick;
    expect_bundle("lw", 32'h110, 4'b0010, 1, 1, 1, 0, 0, 0, 32'h4);
    check("lw.rd", rd, 6);
    instr = 32'hFE208EE3; in_pc = 32'h114;
    tick;
    expect_bundle("beq", 32'h114, 4'b0100, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFC);
    in_valid = 1'b0;
    tick;
    check("drain.out_valid", out_valid, 0);

    // Stall: main + skid fill, third offer refused, then in-order release.
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00C5F533; in_pc = 32'h200;
    check("stall.in_ready0", in_ready, 1);
    tick;
    check("stall.a_valid", out_valid, 1);
    check("stall.a_alu", alu_ctrl, 4'b0000);
    check("stall.a_rd", rd, 10);
    check("stall.in_ready1", in_ready, 1);
    instr = 32'h0020A423; in_pc = 32'h204;
    tick;
    check("stall.in_ready2", in_ready, 0);
    check("stall.a_pc_hold1", out_pc, 32'h200);
    check("stall.a_rd_hold1", rd, 10);
    instr = 32'hFE208EE3; in_pc = 32'h208;
    tick;
    check("stall.in_ready3", in_ready, 0);
    check("stall.a_pc_hold2", out_pc, 32'h200);
    check("stall.a_alu_hold2", alu_ctrl, 4'b0000);
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    expect_bundle("sw", 32'h204, 4'b0010, 0, 1, 0, 1, 0, 0, 32'h8);
    check("sw.in_ready", in_ready, 1);
    tick;
    check("stall.no_third", out_valid, 0);

    // Illegal detection and counting.
    in_valid = 1'b1; instr = 32'h00000000; in_pc = 32'h300;
    tick;
    expect_bundle("ill0", 32'h300, 4'b0010, 0, 0, 0, 0, 0, 1, 32'h0);
    check("ill0.cnt", illegal_count, exp_cnt);
    instr = 32'h022081B3; in_pc = 32'h304;
    tick;
    exp_cnt = 1;
    check("mul.cnt1", illegal_count, exp_cnt);
`ifdef DECODE_MUL_EN
    expect_bundle("mul", 32'h304, 4'b0110, 1, 0, 0, 0, 0, 0, 32'h0);
`else
    expect_bundle("mul", 32'h304, 4'b0010, 0, 0, 0, 0, 0, 1, 32'h0);
    exp_cnt = 2;
`endif
    in_valid = 1'b0;
    tick;
    check("mul.cnt2", illegal_count, exp_cnt);

    // Flush with both slots full and input offered.
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00000000; in_pc = 32'h400;
    tick;
    in_pc = 32'h404;
    tick;
    check("flush.full", in_ready, 0);
    flush = 1'b1; instr = 32'hFFFFFFFF; in_pc = 32'h408;
    tick;
    flush = 1'b0;
    check("flush.out_valid", out_valid, 0);
    check("flush.in_ready", in_ready, 1);
    check("flush.cnt", illegal_count, exp_cnt);
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    check("flush.nothing", out_valid, 0);
    check("flush.cnt2", illegal_count, exp_cnt);
    flush = 1'b1; in_valid = 1'b1; instr = 32'h002081B3; in_pc = 32'h40C;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    check("flush.ignore_in", out_valid, 0);
    tick;
    check("flush.ignore_in2", out_valid, 0);

    // Saturation at 2^CNT_W-1 = 3.
    instr = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i < 3); in_pc = 32'h500 + 4 * i;
      tick;
      if (i > 0) exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
      check($sformatf("sat.cnt%0d", i), illegal_count, exp_cnt);
    end
    check("sat.final", illegal_count, 3);

    // Asynchronous reset mid-transfer.
    in_valid = 1'b1; out_ready = 1'b0; instr = 32'h002081B3; in_pc = 32'h600;
    tick;
    check("rst.pre_valid", out_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_zero("midrst");
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    check("midrst.after", out_valid, 0);
    check("midrst.cnt", illegal_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
